// File: rtl/temp_frame_tx.sv
// rtl/temp_frame_tx.sv - telemetry byte framer feeding the UART tx handshake (optional THRESH_ECHO_EN)
module temp_frame_tx #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    input  logic       temp_warn,
`ifdef THRESH_ECHO_EN
    input  logic [7:0] temp_high,
    input  logic [7:0] temp_low,
`endif
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       frame_busy,
    output logic [7:0] drop_count,
    output logic       timeout_err
);

`ifdef THRESH_ECHO_EN
    localparam int NBYTES = 7;
`else
    localparam int NBYTES = 5;
`endif
    localparam int IDX_W = 3;
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       seq;
    logic             pend_full;
    logic [7:0]       pend_data;
    logic [7:0]       f_sample;
    logic [7:0]       f_flags;
    logic [7:0]       f_chk;
    logic             drop_flag;
    logic             abort_flag;
    logic             timeout_hit;
    logic             last_byte;
    logic             drop_event;
    logic [7:0]       flags_load;
    logic [7:0]       chk_load;
    logic [7:0]       cur_byte;
`ifdef THRESH_ECHO_EN
    logic [7:0]       f_high;
    logic [7:0]       f_low;
`endif

    // A sample landing on a full buffer is a drop; in LOAD the buffer is being
    // drained into the frame registers, so it counts as empty there.
    assign drop_event = en && sample_valid && pend_full && (state != S_LOAD);

    // Flags and checksum for the frame being loaded, built from the buffered sample.
    always_comb begin
        flags_load = {5'b0, abort_flag, drop_flag, temp_warn};
        chk_load   = HEADER ^ seq ^ pend_data ^ flags_load;
`ifdef THRESH_ECHO_EN
        chk_load   = chk_load ^ temp_high ^ temp_low;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the handshake outputs decoded from the state.
    always_comb begin
        state_nxt   = state;
        tx_start    = 1'b0;
        frame_busy  = 1'b0;
        timeout_hit = 1'b0;
        last_byte   = (idx == IDX_LAST);
        case (state)
            S_IDLE: begin
                if (en && (pend_full || sample_valid)) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                frame_busy = 1'b1;
                state_nxt  = S_SEND;
            end
            S_SEND: begin
                frame_busy = 1'b1;
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                frame_busy = 1'b1;
                if (tx_busy) begin
                    state_nxt = S_WAIT_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                frame_busy = 1'b1;
                if (!tx_busy) begin
                    state_nxt = last_byte ? S_DONE : S_SEND;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte select for the current frame position; tx_data is zero outside the start pulse.
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0: cur_byte = HEADER;
            3'd1: cur_byte = seq;      // seq only moves in DONE, so it is stable for the whole frame
            3'd2: cur_byte = f_sample;
            3'd3: cur_byte = f_flags;
`ifdef THRESH_ECHO_EN
            3'd4: cur_byte = f_high;
            3'd5: cur_byte = f_low;
            3'd6: cur_byte = f_chk;
`else
            3'd4: cur_byte = f_chk;
`endif
            default: cur_byte = 8'h00;
        endcase
        tx_data = tx_start ? cur_byte : 8'h00;
    end

    // Byte index and ack-timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            to_cnt <= '0;
        end else begin
            if (state == S_LOAD) begin
                idx <= '0;
            end else if ((state == S_WAIT_IDLE) && !tx_busy && !last_byte) begin
                idx <= idx + 1'b1;
            end
            to_cnt <= (state == S_WAIT_BUSY) ? to_cnt + 1'b1 : '0;
        end
    end

    // One-entry holding buffer; disabling the framer flushes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_full <= 1'b0;
            pend_data <= 8'h00;
        end else begin
            if (!en) begin
                pend_full <= 1'b0;
            end else if (sample_valid) begin
                pend_full <= 1'b1;
                pend_data <= sample;
            end else if (state == S_LOAD) begin
                pend_full <= 1'b0;
            end
        end
    end

    // Drop accounting: saturating counter plus a per-frame flag cleared at LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'h00;
            drop_flag  <= 1'b0;
        end else begin
            if (drop_event) begin
                drop_flag <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (state == S_LOAD) begin
                drop_flag <= 1'b0;
            end
        end
    end

    // Frame capture at LOAD, abort bookkeeping, and sequence advance at DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_sample    <= 8'h00;
            f_flags     <= 8'h00;
            f_chk       <= 8'h00;
            abort_flag  <= 1'b0;
            timeout_err <= 1'b0;
            seq         <= 8'h00;
`ifdef THRESH_ECHO_EN
            f_high      <= 8'h00;
            f_low       <= 8'h00;
`endif
        end else begin
            if (state == S_LOAD) begin
                f_sample   <= pend_data;
                f_flags    <= flags_load;
                f_chk      <= chk_load;
                abort_flag <= 1'b0;
`ifdef THRESH_ECHO_EN
                f_high     <= temp_high;
                f_low      <= temp_low;
`endif
            end
            if (timeout_hit) begin
                abort_flag  <= 1'b1;
                timeout_err <= 1'b1;
            end
            if (state == S_DONE) begin
                seq <= seq + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_temp_frame_tx.sv
// tb/tb_temp_frame_tx.sv - self-checking bench for temp_frame_tx
`timescale 1ns/1ps
module tb_temp_frame_tx;

`ifdef THRESH_ECHO_EN
    localparam int FLEN = 7;
`else
    localparam int FLEN = 5;
`endif

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       en           = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample       = 8'h00;
    logic       temp_warn    = 1'b0;
    logic [7:0] th_v         = 8'h00;
    logic [7:0] tl_v         = 8'h00;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       frame_busy;
    logic [7:0] drop_count;
    logic       timeout_err;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         busy_len  = 10;
    bit         uart_dead = 1'b0;
    int         busy_cnt;
    logic [7:0] byte_q[$];
    logic [7:0] exp_seq;

    typedef struct packed {
        logic [7:0]        s;
        logic              w;
        logic [FLEN*8-1:0] exp;
    } vec_t;
    vec_t tbl [4];

    temp_frame_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample_valid (sample_valid),
        .sample       (sample),
        .temp_warn    (temp_warn),
`ifdef THRESH_ECHO_EN
        .temp_high    (th_v),
        .temp_low     (tl_v),
`endif
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .frame_busy   (frame_busy),
        .drop_count   (drop_count),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // UART model: busy for busy_len cycles after each start pulse, or never when dead.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else if (tx_start && !uart_dead) begin
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign tx_busy = (busy_cnt != 0);

    // Byte monitor.
    always @(negedge clk) begin
        if (tx_start) byte_q.push_back(tx_data);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] s, input logic w);
        @(negedge clk);
        sample       = s;
        temp_warn    = w;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (frame_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", {31'b0, frame_busy}, 32'h0);
        repeat (2) @(negedge clk);
    endtask

    // Wait for a whole frame in the monitor queue and compare with exp (byte 0 at MSB).
    task automatic take_frame(input string tag, input logic [FLEN*8-1:0] exp);
        int n = 0;
        logic [7:0] b;
        while (byte_q.size() < FLEN && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_frame_timeout"}, byte_q.size(), FLEN);
        for (int i = 0; i < FLEN; i++) begin
            b = (byte_q.size() != 0) ? byte_q.pop_front() : 8'h00;
            check($sformatf("%s_b%0d", tag, i), b, exp[(FLEN-1-i)*8 +: 8]);
        end
    endtask

    // Reference frame: header, seq, sample, flags, [thresholds], XOR of all before.
    task automatic expect_frame(input string tag, input logic [7:0] sq, input logic [7:0] s,
                                input logic [7:0] fl);
        logic [7:0] e [FLEN];
        logic [7:0] x;
        logic [FLEN*8-1:0] packed_e;
        e[0] = 8'hA5;
        e[1] = sq;
        e[2] = s;
        e[3] = fl;
        if (FLEN == 7) begin
            e[4] = th_v;
            e[FLEN-2] = tl_v;
        end
        x = 8'h00;
        for (int i = 0; i < FLEN - 1; i++) x = x ^ e[i];
        e[FLEN-1] = x;
        for (int i = 0; i < FLEN; i++) packed_e[(FLEN-1-i)*8 +: 8] = e[i];
        take_frame(tag, packed_e);
    endtask

    initial begin
        int k;
        int n;
        logic [7:0] rs;
        logic       rw;

`ifdef THRESH_ECHO_EN
        tbl[0] = '{s: 8'h3C, w: 1'b0, exp: 56'hA5_00_3C_00_50_40_89};
        tbl[1] = '{s: 8'h00, w: 1'b0, exp: 56'hA5_01_00_00_50_40_B4};
        tbl[2] = '{s: 8'hFF, w: 1'b1, exp: 56'hA5_02_FF_01_50_40_49};
        tbl[3] = '{s: 8'h5A, w: 1'b0, exp: 56'hA5_03_5A_00_50_40_EC};
        th_v = 8'h50;
        tl_v = 8'h40;
`else
        tbl[0] = '{s: 8'h3C, w: 1'b1, exp: 40'hA5_00_3C_01_98};
        tbl[1] = '{s: 8'h00, w: 1'b0, exp: 40'hA5_01_00_00_A4};
        tbl[2] = '{s: 8'hFF, w: 1'b1, exp: 40'hA5_02_FF_01_59};
        tbl[3] = '{s: 8'h5A, w: 1'b0, exp: 40'hA5_03_5A_00_FC};
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", {31'b0, tx_start}, 0);
        check("rst_tx_data", {24'b0, tx_data}, 0);
        check("rst_frame_busy", {31'b0, frame_busy}, 0);
        check("rst_drop_count", {24'b0, drop_count}, 0);
        check("rst_timeout_err", {31'b0, timeout_err}, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven frames, first one with the 10-cycle UART and latency check
        for (int r = 0; r < 4; r++) begin
            busy_len = (r == 0) ? 10 : r + 1;
            pulse(tbl[r].s, tbl[r].w);
            @(negedge clk);
            check($sformatf("latency_row%0d", r), {31'b0, tx_start}, 1);
            take_frame($sformatf("row%0d", r), tbl[r].exp);
            if (r == 0) begin
                check("busy_after_last_byte", {31'b0, frame_busy}, 1);
                n = 0;
                while (frame_busy && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                check("busy_fall_window", {31'b0, (n >= 6 && n <= 14)}, 1);
            end
            wait_idle();
        end
        exp_seq = 8'h04;

        // Overwrite in pending: 10 starts, 20 buffered, 30 replaces it
        busy_len = 10;
        pulse(8'h10, 1'b0);
        repeat (3) @(negedge clk);
        pulse(8'h20, 1'b0);
        repeat (2) @(negedge clk);
        pulse(8'h30, 1'b0);
        expect_frame("ovw_a", exp_seq, 8'h10, 8'h00);
        exp_seq++;
        expect_frame("ovw_b", exp_seq, 8'h30, 8'h02);
        exp_seq++;
        check("ovw_drop_count", {24'b0, drop_count}, 1);
        wait_idle();
        pulse(8'h44, 1'b1);
        expect_frame("ovw_c", exp_seq, 8'h44, 8'h01);
        exp_seq++;
        wait_idle();

        // en=0: samples ignored, no drop counted
        en = 1'b0;
        pulse(8'h77, 1'b1);
        pulse(8'h78, 1'b1);
        repeat (30) @(negedge clk);
        check("dis_no_bytes", byte_q.size(), 0);
        check("dis_drop_count", {24'b0, drop_count}, 1);
        en = 1'b1;

        // en falling mid-frame: the frame completes, a late sample is ignored
        pulse(8'h88, 1'b0);
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        pulse(8'h99, 1'b0);
        expect_frame("en_fall", exp_seq, 8'h88, 8'h00);
        exp_seq++;
        wait_idle();
        repeat (30) @(negedge clk);
        check("en_fall_no_more", byte_q.size(), 0);
        en = 1'b1;

        // Ack timeout: UART never raises busy
        uart_dead = 1'b1;
        pulse(8'h66, 1'b0);
        n = 0;
        while (!tx_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("to_start_seen", {31'b0, tx_start}, 1);
        k = 0;
        while (!timeout_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("to_abort_window", {31'b0, (k >= 16 && k <= 18)}, 1);
        check("to_frame_busy", {31'b0, frame_busy}, 0);
        repeat (5) @(negedge clk);
        check("to_single_byte", byte_q.size(), 1);
        byte_q.delete();
        uart_dead = 1'b0;
        pulse(8'h67, 1'b1);
        expect_frame("to_retry", exp_seq, 8'h67, 8'h05);
        exp_seq++;
        check("to_sticky", {31'b0, timeout_err}, 1);
        wait_idle();
        pulse(8'h68, 1'b0);
        expect_frame("to_after", exp_seq, 8'h68, 8'h00);
        wait_idle();

        // Reset while byte 3 is being started
        busy_len = 10;
        pulse(8'h55, 1'b0);
        k = 0;
        n = 0;
        while (k < 3 && n < 500) begin
            @(negedge clk);
            n++;
            if (tx_start) k++;
        end
        check("mid_rst_reached_b3", k, 3);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_start", {31'b0, tx_start}, 0);
        check("mid_rst_tx_data", {24'b0, tx_data}, 0);
        check("mid_rst_frame_busy", {31'b0, frame_busy}, 0);
        check("mid_rst_drop_count", {24'b0, drop_count}, 0);
        check("mid_rst_timeout_err", {31'b0, timeout_err}, 0);
        repeat (2) @(negedge clk);
        byte_q.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pulse(8'h12, 1'b1);
        expect_frame("post_rst", 8'h00, 8'h12, 8'h01);
        exp_seq = 8'h01;

        // Randomized frames across the seq wrap
        for (int f = 0; f < 257; f++) begin
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            busy_len = $urandom_range(1, 3);
            rs = 8'($urandom);
            rw = 1'($urandom);
`ifdef THRESH_ECHO_EN
            th_v = 8'($urandom);
            tl_v = 8'($urandom);
`endif
            pulse(rs, rw);
            expect_frame($sformatf("rnd%0d", f), exp_seq, rs, {7'b0, rw});
            exp_seq++;
        end
        wait_idle();
        check("final_drop_count", {24'b0, drop_count}, 0);
        check("final_timeout_err", {31'b0, timeout_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
